// File: rtl/ap_mult_err_eval_pkg.sv
// Shared definitions for the approximate-multiplier error evaluator:
// FSM state codes, Galois LFSR tap masks and accumulator width helpers.
`default_nettype none

package ap_mult_err_eval_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Right-shift Galois masks for maximal-length polynomials; only 8/16/24 are tabulated.
  function automatic logic [63:0] lfsr_taps(input int n);
    case (n)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      24:      return 64'h0000_0000_00E1_0000;
      default: return 64'h0000_0000_0000_0000;
    endcase
  endfunction

  function automatic int cnt_width(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sum_width(input int w);
    return 4 * w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ap_mult_err_eval_fifo.sv
// In-order FIFO holding exact products of issued-but-unreturned operand pairs.
// DEPTH must be a power of two so the pointers wrap naturally.
`default_nettype none

module ap_err_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ap_mult_err_eval.sv
// Drives operand pairs into an approximate multiplier (exhaustive or LFSR)
// and accumulates error count, summed and maximum absolute error of its results.
`default_nettype none

module ap_mult_err_eval
  import ap_mult_err_eval_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic [2*WIDTH-1:0]       num_samples,
  input  logic [2*WIDTH-1:0]       seed,
  output logic [WIDTH-1:0]         op_a,
  output logic [WIDTH-1:0]         op_b,
  output logic                     op_valid,
  input  logic                     op_ready,
  input  logic [2*WIDTH-1:0]       prod_ap,
  input  logic                     prod_valid,
  output logic                     busy,
  output logic                     done,
  output logic [2*WIDTH:0]         err_cnt,
  output logic [4*WIDTH:0]         sum_ed,
  output logic [2*WIDTH-1:0]       max_ed,
  output logic                     proto_err
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam int SW = sum_width(WIDTH);
  localparam logic [63:0]   TAPS_ALL = lfsr_taps(PW);
  localparam logic [PW-1:0] TAPS     = TAPS_ALL[PW-1:0];

  logic [1:0]    state_q, state_d;
  logic          mode_q;
  logic [CW-1:0] total_q;
  logic [CW-1:0] issued_q, issued_d;
  logic [PW-1:0] opnd_q, opnd_d;
  logic [CW-1:0] err_cnt_q;
  logic [SW-1:0] sum_ed_q;
  logic [PW-1:0] max_ed_q;
  logic          proto_err_q;

  logic          accept, issue, pop, fifo_full, fifo_empty, ed_nz;
  logic [PW-1:0] exact, head, ed, lfsr_next, seed_eff;

  assign accept    = (state_q == ST_IDLE) && start;
  assign op_valid  = (state_q == ST_RUN) && !fifo_full && (issued_q < total_q);
  assign issue     = op_valid && op_ready;
  assign pop       = prod_valid && !fifo_empty;
  assign op_a      = opnd_q[PW-1:WIDTH];
  assign op_b      = opnd_q[WIDTH-1:0];
  assign exact     = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
  assign ed        = (prod_ap >= head) ? (prod_ap - head) : (head - prod_ap);
  assign ed_nz     = |ed;
  assign lfsr_next = {1'b0, opnd_q[PW-1:1]} ^ (opnd_q[0] ? TAPS : '0);
  // The LFSR must never be seeded with its lock-up state.
  assign seed_eff  = (seed == '0) ? '1 : seed;

  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign err_cnt   = err_cnt_q;
  assign sum_ed    = sum_ed_q;
  assign max_ed    = max_ed_q;
  assign proto_err = proto_err_q;

  ap_err_fifo #(
    .DW    (PW),
    .DEPTH (MAX_OUT)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (accept),
    .push_i  (issue),
    .din_i   (exact),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    opnd_d   = opnd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          issued_d = '0;
          opnd_d   = mode ? seed_eff : '0;
        end
      end
      ST_RUN: begin
        if (issue) begin
          issued_d = issued_q + 1'b1;
          opnd_d   = mode_q ? lfsr_next : opnd_q + 1'b1;
        end
        // A zero-length run has nothing to drain.
        if (total_q == '0) begin
          state_d = ST_DONE;
        end else if (issue && (issued_q + 1'b1 == total_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      total_q  <= '0;
      issued_q <= '0;
      opnd_q   <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      opnd_q   <= opnd_d;
      if (accept) begin
        mode_q  <= mode;
        total_q <= mode ? {1'b0, num_samples} : {1'b1, {PW{1'b0}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q   <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      proto_err_q <= 1'b0;
    end else if (accept) begin
      err_cnt_q   <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (pop) begin
        err_cnt_q <= err_cnt_q + {{(CW-1){1'b0}}, ed_nz};
        sum_ed_q  <= sum_ed_q + {{(SW-PW){1'b0}}, ed};
        if (ed > max_ed_q) max_ed_q <= ed;
      end
      if (prod_valid && fifo_empty) proto_err_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire
